// File: rtl/seq_pkg.sv
// seq_pkg: opcode and ALU constants plus the sequencer state encoding.
// Revision: 1.0
`default_nettype none

package seq_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_JMP   = 3'b101;
  localparam logic [2:0] OP_JZ    = 3'b110;
  localparam logic [2:0] OP_OUT   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    OUT    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_decode.sv
// seq_decode: combinational opcode-to-class mapping for the sequencer.
// Revision: 1.0
`default_nettype none

module seq_decode
  import seq_pkg::*;
(
  input  logic [2:0] opcode,
  output logic       mem_op,
  output logic       store,
  output logic       jump,
  output logic       cond,
  output logic       out
);

  always_comb begin
    mem_op = (opcode == OP_LOAD) || (opcode == OP_ADD) || (opcode == OP_SUB);
    store  = (opcode == OP_STORE);
    jump   = (opcode == OP_JMP);
    cond   = (opcode == OP_JZ);
    out    = (opcode == OP_OUT);
  end

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer; optional SEQ_SINGLE_STEP_EN adds a step input.
// Revision: 1.0
`default_nettype none

module cpu_sequencer
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [7:0] instr,
  input  logic       acc_zero,
  input  logic       run,
  input  logic       uart_ready,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [4:0] new_pc,
  output logic [4:0] mem_addr,
  output logic [7:0] ir,
  output logic       mem_read,
  output logic       mem_write,
  output logic       acc_write,
  output logic       load_sel,
  output logic [1:0] alu_op,
  output logic       uart_send,
  output logic       busy,
  output logic       retire
);

  state_t state, next_state;
  logic   is_mem_op, is_store, is_jump, is_cond, is_out;
  logic   start;

  seq_decode u_decode (
    .opcode (ir[7:5]),
    .mem_op (is_mem_op),
    .store  (is_store),
    .jump   (is_jump),
    .cond   (is_cond),
    .out    (is_out)
  );

`ifdef SEQ_SINGLE_STEP_EN
  // With run low a single step pulse fetches one instruction; the retire
  // path then returns to IDLE because run is still low.
  assign start = run || step;
`else
  assign start = run;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ir    <= 8'h00;
    end else begin
      state <= next_state;
      if (state == FETCH) ir <= instr;
    end
  end

  assign new_pc   = ir[4:0];
  assign mem_addr = ir[4:0];
  assign busy     = (state != IDLE);

  always_comb begin
    next_state = state;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    acc_write  = 1'b0;
    load_sel   = 1'b0;
    alu_op     = ALU_ADD;
    uart_send  = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = FETCH;
      end
      FETCH: begin
        pc_inc     = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        if (is_mem_op) begin
          mem_read   = 1'b1;
          next_state = EXEC;
        end else if (is_out) begin
          next_state = OUT;
        end else begin
          mem_write = is_store;
          pc_load   = is_jump || (is_cond && acc_zero);
          retire    = 1'b1;
        end
      end
      EXEC: begin
        acc_write = 1'b1;
        load_sel  = (ir[7:5] == OP_LOAD);
        alu_op    = (ir[7:5] == OP_SUB) ? ALU_SUB : ALU_ADD;
        retire    = 1'b1;
      end
      OUT: begin
        uart_send = 1'b1;
        retire    = uart_ready;
      end
      default: next_state = IDLE;
    endcase
    // Every instruction boundary decides between continuing and halting.
    if (retire) next_state = run ? FETCH : IDLE;
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed program with a bench-side datapath and phase-based reference model.
// Revision: 1.0
`default_nettype none

module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       uart_ready = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step = 1'b0;
`endif
  logic [7:0] instr;
  logic       acc_zero;
  logic       pc_inc, pc_load, mem_read, mem_write, acc_write, load_sel;
  logic       uart_send, busy, retire;
  logic [4:0] new_pc, mem_addr;
  logic [7:0] ir;
  logic [1:0] alu_op;

  int checks = 0;
  int failures = 0;

  cpu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
`ifdef SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .instr      (instr),
    .acc_zero   (acc_zero),
    .run        (run),
    .uart_ready (uart_ready),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .new_pc     (new_pc),
    .mem_addr   (mem_addr),
    .ir         (ir),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .acc_write  (acc_write),
    .load_sel   (load_sel),
    .alu_op     (alu_op),
    .uart_send  (uart_send),
    .busy       (busy),
    .retire     (retire)
  );

  always #5 clk = ~clk;

  // Surrounding datapath: PC, accumulator, ROM and RAM driven by the strobes.
  logic [7:0] rom [32];
  logic [7:0] ram [32];
  logic [4:0] pc = 5'd0;
  logic [7:0] acc = 8'd0;
  logic [7:0] acc_hist [$];

  assign instr    = rom[pc];
  assign acc_zero = (acc == 8'd0);

  always @(posedge clk) begin
    logic [7:0] nv;
    if (reset) begin
      pc  <= 5'd0;
      acc <= 8'd0;
    end else begin
      if (pc_load) pc <= new_pc;
      else if (pc_inc) pc <= pc + 5'd1;
      if (acc_write) begin
        nv = load_sel ? ram[mem_addr] :
             (alu_op == 2'b01) ? acc - ram[mem_addr] : acc + ram[mem_addr];
        acc <= nv;
        acc_hist.push_back(nv);
      end
      if (mem_write) ram[mem_addr] <= acc;
    end
  end

  // Reference model: busy flag, phase within the instruction, latched word.
  bit       m_busy = 1'b0;
  int       m_phase = 0;
  logic [7:0] m_ir = 8'h00;
  bit       armed = 1'b0;
  int       cyc = 0;
  int       fetch_cyc = 0;
  int       uart_cnt = 0;
  logic [7:0] ret_ir [$];
  int       ret_lat [$];

  always @(negedge clk) begin
    logic [28:0] exp_v, act_v;
    logic e_inc, e_load, e_rd, e_wr, e_aw, e_ls, e_us, e_ret, step_v;
    logic [1:0] e_alu;
    logic [2:0] op;
    cyc++;
    op = m_ir[7:5];
    {e_inc, e_load, e_rd, e_wr, e_aw, e_ls, e_us, e_ret} = '0;
    e_alu = 2'b00;
    if (m_busy) begin
      if (m_phase == 0) e_inc = 1'b1;
      else if (m_phase == 1) begin
        case (op)
          3'b000: e_ret = 1'b1;
          3'b010: begin e_wr = 1'b1; e_ret = 1'b1; end
          3'b101: begin e_load = 1'b1; e_ret = 1'b1; end
          3'b110: begin e_load = acc_zero; e_ret = 1'b1; end
          3'b111: ;
          default: e_rd = 1'b1;
        endcase
      end else if (op == 3'b111) begin
        e_us  = 1'b1;
        e_ret = uart_ready;
      end else begin
        e_aw  = 1'b1;
        e_ls  = (op == 3'b001);
        e_alu = (op == 3'b100) ? 2'b01 : 2'b00;
        e_ret = 1'b1;
      end
    end
    exp_v = {e_inc, e_load, m_ir[4:0], m_ir[4:0], m_ir, e_rd, e_wr, e_aw, e_ls, e_alu, e_us, m_busy, e_ret};
    act_v = {pc_inc, pc_load, new_pc, mem_addr, ir, mem_read, mem_write, acc_write, load_sel, alu_op, uart_send, busy, retire};
    if (armed) begin
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL cycle_outputs cyc=%0d actual=%h required=%h", cyc, act_v, exp_v);
      end
      if (pc_inc === 1'b1) fetch_cyc = cyc;
      if (uart_send === 1'b1) uart_cnt++;
      if (retire === 1'b1) begin
        ret_ir.push_back(ir);
        ret_lat.push_back(cyc - fetch_cyc + 1);
      end
    end
`ifdef SEQ_SINGLE_STEP_EN
    step_v = step;
`else
    step_v = 1'b0;
`endif
    if (reset) begin
      m_busy = 1'b0; m_phase = 0; m_ir = 8'h00;
      armed = 1'b1;
    end else if (!m_busy) begin
      if (run || step_v) begin m_busy = 1'b1; m_phase = 0; end
    end else if (m_phase == 0) begin
      m_ir = instr; m_phase = 1;
    end else if (e_ret) begin
      m_busy = run; m_phase = 0;
    end else begin
      m_phase++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_cond(input int which, input string name);
    bit hit = 1'b0;
    for (int n = 0; n < 300 && !hit; n++) begin
      tick();
      if (which == 0) hit = (uart_send === 1'b1);
      else hit = (pc == 5'd12) && (acc_write === 1'b1);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL timeout_%s actual=0 required=1", name);
    end
  endtask

  initial begin
    logic [7:0] exp_ir [11];
    int         exp_lat [11];
    int         r0;
    foreach (rom[i]) begin rom[i] = 8'h00; ram[i] = 8'h00; end
    rom[0] = 8'h21; rom[1] = 8'h62; rom[2] = 8'h82; rom[3] = 8'hC7;
    rom[4] = 8'h82; rom[5] = 8'hC7; rom[7] = 8'hE0; rom[8] = 8'h00;
    rom[9] = 8'hAB; rom[11] = 8'h21; rom[12] = 8'h43; rom[13] = 8'hE0;
    ram[1] = 8'h05; ram[2] = 8'h05;
    exp_ir  = '{8'h21, 8'h62, 8'h82, 8'hC7, 8'h82, 8'hC7, 8'hE0, 8'h00, 8'hAB, 8'h21, 8'h43};
    exp_lat = '{3, 3, 3, 2, 3, 2, 7, 2, 2, 3, 2};

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick(); tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ir", {24'd0, ir}, 32'd0);
    check("reset_strobes", {25'd0, pc_inc, pc_load, mem_read, mem_write, acc_write, uart_send, retire}, 32'd0);

    run = 1'b1;
    wait_cond(0, "first_out");
    repeat (4) tick();
    uart_ready = 1'b1;
    tick();
    uart_ready = 1'b0;
    check("out_send_cycles", uart_cnt, 5);
    check("acc_hist_len", acc_hist.size(), 4);
    if (acc_hist.size() >= 4) begin
      check("acc_after_load", {24'd0, acc_hist[0]}, 32'd5);
      check("acc_after_add", {24'd0, acc_hist[1]}, 32'd10);
      check("acc_after_sub", {24'd0, acc_hist[2]}, 32'd5);
      check("acc_after_sub2", {24'd0, acc_hist[3]}, 32'd0);
    end

    wait_cond(1, "load_exec");
    run = 1'b0;
    tick(); tick();
    check("halt_busy", {31'd0, busy}, 32'd0);
    check("halt_acc", {24'd0, acc}, 32'd5);

    run = 1'b1;
    wait_cond(0, "second_out");
    reset = 1'b1;
    tick();
    check("rst_out_ir", {24'd0, ir}, 32'd0);
    check("rst_out_strobes", {22'd0, busy, pc_inc, pc_load, mem_read, mem_write, acc_write, load_sel, uart_send, retire, new_pc == 5'd0}, 32'd1);
    run = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    check("retire_count", ret_ir.size(), 11);
    for (int i = 0; i < 11 && i < ret_ir.size(); i++) begin
      check($sformatf("retire_ir_%0d", i), {24'd0, ret_ir[i]}, {24'd0, exp_ir[i]});
      check($sformatf("retire_lat_%0d", i), ret_lat[i], exp_lat[i]);
    end

`ifdef SEQ_SINGLE_STEP_EN
    r0 = ret_ir.size();
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (6) tick();
    check("step_retires", ret_ir.size() - r0, 1);
    check("step_busy", {31'd0, busy}, 32'd0);
    check("step_acc", {24'd0, acc}, 32'd5);
`else
    r0 = 0;
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous, active-high reset, reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 instr  input  8  ROM word at current PC; [7:5] opcode, [4:0] operand.
REQ-005 acc_zero  input  1  combinational (ACC == 0).
REQ-006 run  input  1  level; 1 = execute continuously, 0 = halt at the next instruction boundary.
REQ-007 uart_ready  input  1  UART sink can accept a byte this cycle.
REQ-008 pc_inc / pc_load  output  1 each  PC increment enable and PC load enable; pc_load has priority.
REQ-009 new_pc / mem_addr  output  5 each  jump target and data-memory address, both equal to ir[4:0].
REQ-010 ir  output  8  latched instruction register.
REQ-011 mem_read / mem_write / acc_write / load_sel  output  1 each  datapath strobes; load_sel=1 selects memory data to ACC.
REQ-012 alu_op  output  2  00=ADD, 01=SUB.
REQ-013 uart_send  output  1  byte-valid strobe to UART.
REQ-014 busy / retire  output  1 each  not IDLE / single-cycle pulse on the last cycle of each instruction.

Function
REQ-015 States SHALL be IDLE, FETCH, DECODE, EXEC, OUT.
REQ-016 IDLE: all strobes 0; go to FETCH when run=1.
REQ-017 FETCH: ir <= instr; pc_inc=1; go to DECODE.
REQ-018 DECODE (NOP, opcode 000): retire=1.
REQ-019 DECODE (STORE, 010): mem_write=1; retire=1.
REQ-020 DECODE (JMP, 101): pc_load=1; retire=1.
REQ-021 DECODE (JZ, 110): pc_load=acc_zero; retire=1.
REQ-022 DECODE (LOAD/ADD/SUB, 001/011/100): mem_read=1; go to EXEC.
REQ-023 DECODE (OUT, 111): go to OUT.
REQ-024 EXEC: acc_write=1; LOAD sets load_sel=1, ADD sets alu_op=00, SUB sets alu_op=01; retire=1.
REQ-025 OUT: uart_send=1 every cycle until uart_ready=1; completion is the cycle where uart_send and uart_ready are both 1, with retire=1 in that cycle.
REQ-026 Every cycle with retire=1 SHALL be followed by FETCH if run=1, otherwise by IDLE.
REQ-027 Latency: NOP/STORE/JMP/JZ take 2 cycles; LOAD/ADD/SUB take 3; OUT takes 2 plus the number of OUT cycles, minimum 3.
REQ-028 A run deassert mid-instruction SHALL NOT abort the instruction; it completes, then the block enters IDLE.
REQ-029 JZ SHALL sample acc_zero in DECODE, which reflects ACC after the previous instruction retired.
REQ-030 PC wrap-around from 31 to 0 SHALL be handled by the PC (5-bit); the sequencer applies no special case.
REQ-031 mem_addr and new_pc SHALL always equal ir[4:0]; all other strobes SHALL be 0 outside the states named above.

Reset
REQ-032 Reset SHALL force state=IDLE and ir=8'h00 on the next clk edge from any state, including mid-OUT wait.
REQ-033 During and after reset, all outputs SHALL be 0 until run=1.

Configuration
REQ-034 With SEQ_SINGLE_STEP_EN defined: the block SHALL add input step (1 bit); a step=1 cycle while in IDLE with run=0 executes exactly one instruction, then returns to IDLE; step is ignored in all other states.
REQ-035 With SEQ_SINGLE_STEP_EN not defined: the step port and its logic SHALL be absent, and behaviour is exactly as specified in REQ-015 to REQ-031.

Structure
REQ-036 Package seq_pkg SHALL hold the opcode constants, the ALU op codes, and the state enumeration.
REQ-037 One combinational sub-module, seq_decode, SHALL map opcode to class flags (mem_op, store, jump, cond, out); all registers stay in cpu_sequencer.

Verification
REQ-038 Apply reset, then run=1, with ROM[0]=8'h21 (LOAD 1) and RAM[1]=8'h05 -> expect FETCH, DECODE with mem_read=1, EXEC with acc_write=1, load_sel=1 and retire=1 on cycle 3, then ACC=5.
REQ-039 Execute ADD then SUB with ACC=5 and RAM[2]=8'h05 (instr 8'h62, 8'h82) -> expect alu_op 00 then 01, ACC=10 then 5, 3 cycles each.
REQ-040 Execute JZ 8'hC7 with acc_zero=1 -> expect pc_load=1 and new_pc=7 in DECODE; with acc_zero=0 -> expect pc_load=0 and the PC advances by 1.
REQ-041 Execute OUT 8'hE0 with uart_ready held 0 for 4 cycles -> expect uart_send high for 5 cycles, and retire on the cycle uart_ready=1.
REQ-042 Drop run in the EXEC of a LOAD -> expect the LOAD to retire, then IDLE; assert reset in the OUT wait -> expect IDLE, ir=0 and all outputs 0 the next cycle.
REQ-043 With SEQ_SINGLE_STEP_EN defined, run=0 and a 1-cycle step pulse -> expect exactly one retire pulse, then busy=0.
